// File: rtl/alu_control_pipelined_pkg.sv
// Shared definitions for the pipelined ALU control block.
// Contents: decoder field widths, selector constants ({alu_op, funct}),
// ALU operation codes and the mult/div sequencer state encoding.
package alu_control_pipelined_pkg;

  localparam int unsigned AOP_W  = 3;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned CODE_W = 4;

  // alu_op classes from the main control unit
  localparam logic [AOP_W-1:0] AOP_LWSW   = 3'b000;
  localparam logic [AOP_W-1:0] AOP_ORI    = 3'b001;
  localparam logic [AOP_W-1:0] AOP_ANDI   = 3'b010;
  localparam logic [AOP_W-1:0] AOP_LUI    = 3'b011;
  localparam logic [AOP_W-1:0] AOP_ADDI   = 3'b100;
  localparam logic [AOP_W-1:0] AOP_BRANCH = 3'b101;
  localparam logic [AOP_W-1:0] AOP_RTYPE  = 3'b111;

  // R-type function fields (valid with AOP_RTYPE)
  localparam logic [FN_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [FN_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [FN_W-1:0] FN_MFHI = 6'b010000;
  localparam logic [FN_W-1:0] FN_MFLO = 6'b010010;
  localparam logic [FN_W-1:0] FN_MULT = 6'b011000;
  localparam logic [FN_W-1:0] FN_DIV  = 6'b011010;
  localparam logic [FN_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FN_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FN_W-1:0] FN_SLT  = 6'b101010;

  // ALU operation codes
  localparam logic [CODE_W-1:0] ALU_AND     = 4'b0000;
  localparam logic [CODE_W-1:0] ALU_OR      = 4'b0001;
  localparam logic [CODE_W-1:0] ALU_SLL     = 4'b0010;
  localparam logic [CODE_W-1:0] ALU_ADD     = 4'b0011;
  localparam logic [CODE_W-1:0] ALU_SUB     = 4'b0100;
  localparam logic [CODE_W-1:0] ALU_SRL     = 4'b0101;
  localparam logic [CODE_W-1:0] ALU_NOR     = 4'b0110;
  localparam logic [CODE_W-1:0] ALU_SLT     = 4'b0111;
  localparam logic [CODE_W-1:0] ALU_LUI     = 4'b1000;
  localparam logic [CODE_W-1:0] ALU_ILLEGAL = 4'b1001;
  localparam logic [CODE_W-1:0] ALU_MFHI    = 4'b1010;
  localparam logic [CODE_W-1:0] ALU_MFLO    = 4'b1011;
  localparam logic [CODE_W-1:0] ALU_MD      = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational {alu_op, funct} decoder shared by the single-cycle and
// pipelined ALU control blocks.
// Ports: alu_op, funct in; code (ALU operation), illegal (no table row hit),
//        is_md (MULT/DIV), md_op (0=MULT, 1=DIV), is_md_dep (MULT/DIV/MFHI/MFLO).
module alu_control_decode
  import alu_control_pipelined_pkg::*;
(
  input  logic [AOP_W-1:0]  alu_op,
  input  logic [FN_W-1:0]   funct,
  output logic [CODE_W-1:0] code,
  output logic              illegal,
  output logic              is_md,
  output logic              md_op,
  output logic              is_md_dep
);

  always_comb begin
    code      = ALU_ILLEGAL;
    illegal   = 1'b1;
    is_md     = 1'b0;
    md_op     = 1'b0;
    is_md_dep = 1'b0;
    case (alu_op)
      AOP_LWSW, AOP_ADDI: begin code = ALU_ADD; illegal = 1'b0; end
      AOP_BRANCH:         begin code = ALU_SUB; illegal = 1'b0; end
      AOP_ORI:            begin code = ALU_OR;  illegal = 1'b0; end
      AOP_ANDI:           begin code = ALU_AND; illegal = 1'b0; end
      AOP_LUI:            begin code = ALU_LUI; illegal = 1'b0; end
      AOP_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_OR:   code = ALU_OR;
          FN_AND:  code = ALU_AND;
          FN_SLL:  code = ALU_SLL;
          FN_SRL:  code = ALU_SRL;
          FN_NOR:  code = ALU_NOR;
          FN_SLT:  code = ALU_SLT;
          FN_MFHI: begin code = ALU_MFHI; is_md_dep = 1'b1; end
          FN_MFLO: begin code = ALU_MFLO; is_md_dep = 1'b1; end
          FN_MULT: begin code = ALU_MD; is_md = 1'b1; is_md_dep = 1'b1; end
          FN_DIV:  begin code = ALU_MD; is_md = 1'b1; md_op = 1'b1; is_md_dep = 1'b1; end
          default: begin code = ALU_ILLEGAL; illegal = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control_pipelined.sv
// Pipelined ALU control: registers the decoded ALU operation one cycle after
// acceptance and sequences multi-cycle MULT/DIV with a busy counter.
// Ports: clk, reset (sync, active-low); valid_i/alu_op_i/alu_function_i decode
//        request; stall_i downstream hold; stall_o combinational back-pressure;
//        valid_o/alu_operation_o/illegal_o registered result; md_start_o,
//        md_op_o, md_busy_o mult/div unit control.
module alu_control_pipelined
  import alu_control_pipelined_pkg::*;
#(
  parameter int unsigned ALU_OP_WIDTH  = 3,
  parameter int unsigned FUNCT_WIDTH   = 6,
  parameter int unsigned ALU_SEL_WIDTH = 4,
  parameter int unsigned MULT_CYCLES   = 4,
  parameter int unsigned DIV_CYCLES    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  logic [ALU_OP_WIDTH-1:0]  alu_op_i,
  input  logic [FUNCT_WIDTH-1:0]   alu_function_i,
  input  logic                     stall_i,
  output logic                     stall_o,
  output logic                     valid_o,
  output logic [ALU_SEL_WIDTH-1:0] alu_operation_o,
  output logic                     illegal_o,
  output logic                     md_start_o,
  output logic                     md_op_o,
  output logic                     md_busy_o
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [CODE_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_is_md;
  logic              dec_md_op;
  logic              dec_is_md_dep;

  md_state_t         state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              accept;
  logic              start_md;

  alu_control_decode u_decode (
    .alu_op    (AOP_W'(alu_op_i)),
    .funct     (FN_W'(alu_function_i)),
    .code      (dec_code),
    .illegal   (dec_illegal),
    .is_md     (dec_is_md),
    .md_op     (dec_md_op),
    .is_md_dep (dec_is_md_dep)
  );

  // Hold dependent instructions until the final busy cycle (count==0).
  assign stall_o   = (state == ST_BUSY) && (count != '0) && valid_i && dec_is_md_dep;
  assign accept    = valid_i && !stall_i && !stall_o;
  assign start_md  = accept && dec_is_md;
  assign md_busy_o = (state == ST_BUSY);

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Sequencer next state; a new MULT/DIV at count==0 re-arms immediately.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (start_md) begin
      state_nxt = ST_BUSY;
      count_nxt = dec_md_op ? DIV_LOAD : MULT_LOAD;
    end else if (state == ST_BUSY) begin
      if (count == '0) begin
        state_nxt = ST_IDLE;
      end else begin
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  // Output register; stall_i freezes the result, idle cycles only drop valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_o         <= 1'b0;
      alu_operation_o <= ALU_SEL_WIDTH'(ALU_ILLEGAL);
      illegal_o       <= 1'b0;
      md_start_o      <= 1'b0;
      md_op_o         <= 1'b0;
    end else begin
      md_start_o <= start_md;
      if (start_md) begin
        md_op_o <= dec_md_op;
      end
      if (!stall_i) begin
        valid_o <= accept;
        if (accept) begin
          alu_operation_o <= ALU_SEL_WIDTH'(dec_code);
          illegal_o       <= dec_illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_control_pipelined.sv
// Directed self-checking bench for alu_control_pipelined (MULT=4, DIV=32).
module tb_alu_control_pipelined;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [2:0] alu_op_i;
  logic [5:0] alu_function_i;
  logic       stall_i;
  logic       stall_o;
  logic       valid_o;
  logic [3:0] alu_operation_o;
  logic       illegal_o;
  logic       md_start_o;
  logic       md_op_o;
  logic       md_busy_o;

  int checks   = 0;
  int failures = 0;

  alu_control_pipelined #(
    .ALU_OP_WIDTH (3),
    .FUNCT_WIDTH  (6),
    .ALU_SEL_WIDTH(4),
    .MULT_CYCLES  (4),
    .DIV_CYCLES   (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .alu_op_i       (alu_op_i),
    .alu_function_i (alu_function_i),
    .stall_i        (stall_i),
    .stall_o        (stall_o),
    .valid_o        (valid_o),
    .alu_operation_o(alu_operation_o),
    .illegal_o      (illegal_o),
    .md_start_o     (md_start_o),
    .md_op_o        (md_op_o),
    .md_busy_o      (md_busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] aop, input logic [5:0] fn);
    valid_i        = 1'b1;
    alu_op_i       = aop;
    alu_function_i = fn;
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    #1;
  endtask

  logic [2:0] seq_op  [4];
  logic [5:0] seq_fn  [4];
  logic [3:0] seq_exp [4];
  int busy_cnt;

  initial begin
    reset = 1'b0; valid_i = 1'b0; alu_op_i = '0; alu_function_i = '0; stall_i = 1'b0;
    seq_op[0] = 3'b111; seq_fn[0] = 6'b100010; seq_exp[0] = 4'b0100;  // SUB
    seq_op[1] = 3'b001; seq_fn[1] = 6'b010101; seq_exp[1] = 4'b0001;  // ORI
    seq_op[2] = 3'b011; seq_fn[2] = 6'b111000; seq_exp[2] = 4'b1000;  // LUI
    seq_op[3] = 3'b111; seq_fn[3] = 6'b101010; seq_exp[3] = 4'b0111;  // SLT

    // Reset state
    tick(); tick();
    check("rst_code", 32'(alu_operation_o), 32'h9);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_illegal", 32'(illegal_o), 32'h0);
    check("rst_busy", 32'(md_busy_o), 32'h0);
    check("rst_start", 32'(md_start_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    reset = 1'b1;

    // ADD, one-cycle latency
    issue(3'b111, 6'b100000);
    tick();
    check("add_code", 32'(alu_operation_o), 32'h3);
    check("add_valid", 32'(valid_o), 32'h1);
    check("add_illegal", 32'(illegal_o), 32'h0);

    // Back-to-back, no bubbles
    for (int i = 0; i < 4; i++) begin
      issue(seq_op[i], seq_fn[i]);
      tick();
      check("b2b_code", 32'(alu_operation_o), 32'(seq_exp[i]));
      check("b2b_valid", 32'(valid_o), 32'h1);
    end
    idle();
    tick();
    check("idle_valid", 32'(valid_o), 32'h0);
    check("idle_code_hold", 32'(alu_operation_o), 32'h7);

    // MULT then dependent MFLO
    issue(3'b111, 6'b011000);
    check("mult_nostall", 32'(stall_o), 32'h0);
    tick();
    check("mult_start", 32'(md_start_o), 32'h1);
    check("mult_op", 32'(md_op_o), 32'h0);
    check("mult_code", 32'(alu_operation_o), 32'hC);
    busy_cnt = 0;
    issue(3'b111, 6'b010010);
    for (int i = 0; i < 3; i++) begin
      check("mflo_stall", 32'(stall_o), 32'h1);
      if (md_busy_o) busy_cnt++;
      tick();
      if (i == 0) check("mult_pulse", 32'(md_start_o), 32'h0);
    end
    check("mflo_release", 32'(stall_o), 32'h0);
    check("mflo_stalled_valid", 32'(valid_o), 32'h0);
    if (md_busy_o) busy_cnt++;
    tick();
    check("mult_busy_cycles", 32'(busy_cnt), 32'd4);
    check("mult_done", 32'(md_busy_o), 32'h0);
    check("mflo_code", 32'(alu_operation_o), 32'hB);
    check("mflo_valid", 32'(valid_o), 32'h1);

    // DIV then independent ADDI
    issue(3'b111, 6'b011010);
    tick();
    check("div_start", 32'(md_start_o), 32'h1);
    check("div_op", 32'(md_op_o), 32'h1);
    busy_cnt = md_busy_o ? 1 : 0;
    issue(3'b100, 6'b110011);
    check("addi_nostall", 32'(stall_o), 32'h0);
    tick();
    check("addi_code", 32'(alu_operation_o), 32'h3);
    check("addi_valid", 32'(valid_o), 32'h1);
    check("div_pulse", 32'(md_start_o), 32'h0);
    if (md_busy_o) busy_cnt++;
    idle();
    for (int n = 0; n < 40 && md_busy_o; n++) begin
      tick();
      if (md_busy_o) busy_cnt++;
    end
    check("div_busy_cycles", 32'(busy_cnt), 32'd32);

    // Illegal selectors, then recovery
    issue(3'b111, 6'b111111);
    tick();
    check("ill_code", 32'(alu_operation_o), 32'h9);
    check("ill_flag", 32'(illegal_o), 32'h1);
    check("ill_start", 32'(md_start_o), 32'h0);
    check("ill_busy", 32'(md_busy_o), 32'h0);
    issue(3'b110, 6'b011000);
    tick();
    check("ill110_flag", 32'(illegal_o), 32'h1);
    check("ill110_start", 32'(md_start_o), 32'h0);
    issue(3'b010, 6'b000000);
    tick();
    check("andi_code", 32'(alu_operation_o), 32'h0);
    check("andi_illegal", 32'(illegal_o), 32'h0);

    // Downstream stall freezes the output register
    stall_i = 1'b1;
    issue(3'b111, 6'b100111);
    tick();
    check("stall_code_hold", 32'(alu_operation_o), 32'h0);
    check("stall_valid_hold", 32'(valid_o), 32'h1);
    stall_i = 1'b0;
    #1;
    tick();
    check("nor_code", 32'(alu_operation_o), 32'h6);
    check("nor_valid", 32'(valid_o), 32'h1);

    // Reset in the middle of DIV (count 10)
    issue(3'b111, 6'b011010);
    tick();
    idle();
    for (int i = 0; i < 21; i++) tick();
    check("div_mid_busy", 32'(md_busy_o), 32'h1);
    reset = 1'b0;
    tick();
    check("mrst_busy", 32'(md_busy_o), 32'h0);
    check("mrst_valid", 32'(valid_o), 32'h0);
    check("mrst_code", 32'(alu_operation_o), 32'h9);
    check("mrst_op", 32'(md_op_o), 32'h0);
    reset = 1'b1;
    issue(3'b111, 6'b010000);
    check("mrst_mfhi_nostall", 32'(stall_o), 32'h0);
    tick();
    check("mrst_mfhi_code", 32'(alu_operation_o), 32'hA);

    // MULT at count==0 re-arms; MFHI at count==0 passes and FSM idles
    issue(3'b111, 6'b011000);
    tick();
    idle();
    tick(); tick(); tick();
    check("cnt0_busy", 32'(md_busy_o), 32'h1);
    issue(3'b111, 6'b011000);
    check("cnt0_mult_nostall", 32'(stall_o), 32'h0);
    tick();
    check("rearm_start", 32'(md_start_o), 32'h1);
    check("rearm_busy", 32'(md_busy_o), 32'h1);
    idle();
    tick(); tick(); tick();
    issue(3'b111, 6'b010000);
    check("cnt0_mfhi_nostall", 32'(stall_o), 32'h0);
    tick();
    check("cnt0_mfhi_code", 32'(alu_operation_o), 32'hA);
    check("cnt0_mfhi_valid", 32'(valid_o), 32'h1);
    check("cnt0_idle", 32'(md_busy_o), 32'h0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
